// File: rtl/countdown_timer_if.sv
// Purpose: control/status bundle between a countdown_timer and its controller.
// Latency: none; this file only groups signals.
// Backpressure: none; the timer samples the controls on every clock edge.
interface countdown_timer_if #(
    parameter int SIZE = 4
);
    logic            LOAD;
    logic [SIZE-1:0] D;
    logic            START;
    logic            STOP;
    logic            E;
    logic            RELOAD_EN;
    logic [SIZE-1:0] TEMPO;
    logic            end_time;
    logic            busy;

    // Timer side.
    modport slave (
        input  LOAD, D, START, STOP, E, RELOAD_EN,
        output TEMPO, end_time, busy
    );

    // Controller side.
    modport master (
        output LOAD, D, START, STOP, E, RELOAD_EN,
        input  TEMPO, end_time, busy
    );
endinterface

// File: rtl/countdown_timer.sv
// Purpose: loadable down-counter with IDLE/RUN/PAUSE control, optional auto-reload and a terminal-count pulse.
// Latency: TEMPO/end_time update on the edge that samples E; busy follows the state one edge after START/STOP.
// Backpressure: none; controls are sampled every cycle with priority LOAD > STOP > START > E.
module countdown_timer #(
    parameter int SIZE    = 4,
    parameter int MAX_VAL = 9
) (
    input  logic              CLKT,
    input  logic              R,
    countdown_timer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [SIZE-1:0] MAX_V = SIZE'(MAX_VAL);
    localparam logic [SIZE-1:0] ONE   = SIZE'(1);
    localparam logic [SIZE-1:0] ZERO  = '0;

    state_t          state_q, state_d;
    logic [SIZE-1:0] tempo_q, tempo_d;
    logic [SIZE-1:0] preset_q, preset_d;
    logic            end_q, end_d;
    logic            busy_q;
    logic [SIZE-1:0] load_v;

    // State and datapath registers; busy is registered from the next state so it tracks RUN exactly.
    always_ff @(posedge CLKT or negedge R) begin
        if (!R) begin
            state_q  <= IDLE;
            tempo_q  <= ZERO;
            preset_q <= ZERO;
            end_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tempo_q  <= tempo_d;
            preset_q <= preset_d;
            end_q    <= end_d;
            busy_q   <= (state_d == RUN);
        end
    end

    // Next-state and datapath: LOAD overrides everything, otherwise per-state handling.
    always_comb begin
        state_d  = state_q;
        tempo_d  = tempo_q;
        preset_d = preset_q;
        end_d    = 1'b0;
        load_v   = (bus.D > MAX_V) ? MAX_V : bus.D;

        if (bus.LOAD) begin
            // Any terminal tick in the same cycle is dropped along with its pulse.
            preset_d = load_v;
            tempo_d  = load_v;
            state_d  = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // A zero count would immediately underflow, so it never starts.
                    if (bus.START && !bus.STOP && (tempo_q != ZERO)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (bus.STOP) begin
                        state_d = PAUSE;
                    end else if (bus.E) begin
                        if (tempo_q > ONE) begin
                            tempo_d = tempo_q - ONE;
                        end else if (tempo_q == ONE) begin
                            end_d = 1'b1;
                            if (bus.RELOAD_EN) begin
                                tempo_d = preset_q;
                            end else begin
                                tempo_d = ZERO;
                                state_d = IDLE;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (bus.START && !bus.STOP) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.TEMPO    = tempo_q;
    assign bus.end_time = end_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed vectors queue expected outputs tagged with the
// clock cycle they apply to; a monitor pops and compares them after each edge.
module tb_countdown_timer;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   cyc;

    typedef struct {
        int         at_cyc;
        logic [3:0] tempo;
        logic       end_t;
        logic       busy;
        string      name;
    } exp_t;

    exp_t sb[$];

    countdown_timer_if #(.SIZE(4)) ifc ();

    countdown_timer #(.SIZE(4), .MAX_VAL(9)) dut (
        .CLKT (clk),
        .R    (rst_n),
        .bus  (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got tempo=%0d end=%0b busy=%0b, expected tempo=%0d end=%0b busy=%0b",
                     name, got[5:2], got[1], got[0], want[5:2], want[1], want[0]);
        end
    endtask

    // Monitor: counts edges, then compares every expectation due at this cycle.
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #3;
            while (sb.size() != 0 && sb[0].at_cyc <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                if (e.at_cyc < cyc) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL %s: expectation for cycle %0d not sampled, now cycle %0d",
                             e.name, e.at_cyc, cyc);
                end else begin
                    check(e.name, {ifc.TEMPO, ifc.end_time, ifc.busy},
                          {e.tempo, e.end_t, e.busy});
                end
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic ld, input logic [3:0] d, input logic st, input logic sp,
                        input logic e, input logic rl,
                        input logic [3:0] x_tempo, input logic x_end, input logic x_busy,
                        input string name);
        exp_t x;
        @(posedge clk);
        #1;
        ifc.LOAD      = ld;
        ifc.D         = d;
        ifc.START     = st;
        ifc.STOP      = sp;
        ifc.E         = e;
        ifc.RELOAD_EN = rl;
        x.at_cyc = cyc + 1;
        x.tempo  = x_tempo;
        x.end_t  = x_end;
        x.busy   = x_busy;
        x.name   = name;
        sb.push_back(x);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        ifc.LOAD = 1'b0; ifc.D = 4'd0; ifc.START = 1'b0;
        ifc.STOP = 1'b0; ifc.E = 1'b0; ifc.RELOAD_EN = 1'b0;
        #2;
        check("reset_state", {ifc.TEMPO, ifc.end_time, ifc.busy}, 6'd0);
        #10 rst_n = 1'b1;

        // One-shot D=3, E held high.
        step(1, 4'd3, 0, 0, 0, 0, 4'd3, 0, 0, "os_load3");
        step(0, 4'd0, 1, 0, 0, 0, 4'd3, 0, 1, "os_start");
        step(0, 4'd0, 0, 0, 1, 0, 4'd2, 0, 1, "os_t2");
        step(0, 4'd0, 0, 0, 1, 0, 4'd1, 0, 1, "os_t1");
        step(0, 4'd0, 0, 0, 1, 0, 4'd0, 1, 0, "os_term");
        step(0, 4'd0, 0, 0, 1, 0, 4'd0, 0, 0, "os_idle_after");

        // Auto-reload D=4, 8 ticks.
        step(1, 4'd4, 0, 0, 0, 1, 4'd4, 0, 0, "ar_load4");
        step(0, 4'd0, 1, 0, 0, 1, 4'd4, 0, 1, "ar_start");
        step(0, 4'd0, 0, 0, 1, 1, 4'd3, 0, 1, "ar_e1");
        step(0, 4'd0, 0, 0, 1, 1, 4'd2, 0, 1, "ar_e2");
        step(0, 4'd0, 0, 0, 1, 1, 4'd1, 0, 1, "ar_e3");
        step(0, 4'd0, 0, 0, 1, 1, 4'd4, 1, 1, "ar_e4_reload");
        step(0, 4'd0, 0, 0, 1, 1, 4'd3, 0, 1, "ar_e5");
        step(0, 4'd0, 0, 0, 1, 1, 4'd2, 0, 1, "ar_e6");
        step(0, 4'd0, 0, 0, 1, 1, 4'd1, 0, 1, "ar_e7");
        step(0, 4'd0, 0, 0, 1, 1, 4'd4, 1, 1, "ar_e8_reload");
        step(0, 4'd0, 0, 1, 0, 1, 4'd4, 0, 0, "ar_stop");
        step(1, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, "ar_clear");

        // Clamp D=15 to 9, then 9 ticks to terminal.
        step(1, 4'd15, 0, 0, 0, 0, 4'd9, 0, 0, "clamp_load");
        step(0, 4'd0, 1, 0, 0, 0, 4'd9, 0, 1, "clamp_start");
        for (int i = 8; i >= 1; i--) begin
            step(0, 4'd0, 0, 0, 1, 0, 4'(i), 0, 1, $sformatf("clamp_tick_%0d", i));
        end
        step(0, 4'd0, 0, 0, 1, 0, 4'd0, 1, 0, "clamp_term");

        // Pause/resume.
        step(1, 4'd8, 0, 0, 0, 0, 4'd8, 0, 0, "pz_load8");
        step(0, 4'd0, 1, 0, 0, 0, 4'd8, 0, 1, "pz_start");
        step(0, 4'd0, 0, 0, 1, 0, 4'd7, 0, 1, "pz_t7");
        step(0, 4'd0, 0, 0, 1, 0, 4'd6, 0, 1, "pz_t6");
        step(0, 4'd0, 0, 1, 1, 0, 4'd6, 0, 0, "pz_stop_e");
        step(0, 4'd0, 0, 0, 1, 0, 4'd6, 0, 0, "pz_e_ign1");
        step(0, 4'd0, 0, 0, 1, 0, 4'd6, 0, 0, "pz_e_ign2");
        step(0, 4'd0, 1, 1, 0, 0, 4'd6, 0, 0, "pz_start_stop");
        step(0, 4'd0, 1, 0, 0, 0, 4'd6, 0, 1, "pz_resume");
        step(0, 4'd0, 0, 0, 1, 0, 4'd5, 0, 1, "pz_t5");
        step(0, 4'd0, 0, 0, 0, 0, 4'd5, 0, 1, "pz_hold_e0");

        // Run down to 1, then LOAD coincident with the terminal tick.
        step(0, 4'd0, 0, 0, 1, 0, 4'd4, 0, 1, "ld_t4");
        step(0, 4'd0, 0, 0, 1, 0, 4'd3, 0, 1, "ld_t3");
        step(0, 4'd0, 0, 0, 1, 0, 4'd2, 0, 1, "ld_t2");
        step(0, 4'd0, 0, 0, 1, 0, 4'd1, 0, 1, "ld_t1");
        step(1, 4'd7, 0, 0, 1, 0, 4'd7, 0, 0, "ld_over_term");
        step(0, 4'd0, 0, 0, 1, 0, 4'd7, 0, 0, "ld_idle_e");
        step(1, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, "zero_load");
        step(0, 4'd0, 1, 0, 0, 0, 4'd0, 0, 0, "zero_start_ign");
        step(0, 4'd0, 0, 0, 1, 0, 4'd0, 0, 0, "zero_idle_e");

        // Auto-reload with preset 1 pulses on every tick.
        step(1, 4'd1, 0, 0, 0, 1, 4'd1, 0, 0, "p1_load");
        step(0, 4'd0, 1, 0, 0, 1, 4'd1, 0, 1, "p1_start");
        step(0, 4'd0, 0, 0, 1, 1, 4'd1, 1, 1, "p1_e1");
        step(0, 4'd0, 0, 0, 1, 1, 4'd1, 1, 1, "p1_e2");
        step(0, 4'd0, 0, 0, 0, 1, 4'd1, 0, 1, "p1_e0");

        // Asynchronous reset mid-RUN at TEMPO=5.
        step(1, 4'd7, 0, 0, 0, 0, 4'd7, 0, 0, "rs_load7");
        step(0, 4'd0, 1, 0, 0, 0, 4'd7, 0, 1, "rs_start");
        step(0, 4'd0, 0, 0, 1, 0, 4'd6, 0, 1, "rs_t6");
        step(0, 4'd0, 0, 0, 1, 0, 4'd5, 0, 1, "rs_t5");
        step(0, 4'd0, 0, 0, 0, 0, 4'd5, 0, 1, "rs_hold5");
        @(posedge clk);
        #4;
        rst_n = 1'b0;
        #1;
        check("async_reset_mid_run", {ifc.TEMPO, ifc.end_time, ifc.busy}, 6'd0);
        #2 rst_n = 1'b1;
        step(0, 4'd0, 0, 0, 1, 0, 4'd0, 0, 0, "rs_after_idle");
        step(0, 4'd0, 1, 0, 0, 0, 4'd0, 0, 0, "rs_after_start_ign");

        repeat (3) @(posedge clk);
        #5;
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL %s: expectation for cycle %0d never compared", e.name, e.at_cyc);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
